// File: rtl/ifetch_unit.sv
// Instruction fetch front end: issues PC addresses to imem over req/gnt, tracks in-order
// responses, buffers {pc,inst} for decode. Optional same-cycle bypass under IFETCH_BYPASS_EN.
module ifetch_unit #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_addr,
    input  logic        jp_en,
    output logic        pc_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        dec_ready
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   r_apc   [DEPTH];
    logic [31:0]   r_opc   [DEPTH];
    logic [31:0]   r_oinst [DEPTH];
    logic [PW-1:0] r_a_wp, r_a_rp, r_o_wp, r_o_rp;
    logic [CW-1:0] r_live, r_drop, r_cnt;

    logic [CW+1:0] w_used;
    logic          w_req, w_gnt, w_rsp, w_stale, w_rsp_live;
    logic          w_fifo_vld, w_byp, w_pop, w_push;
    logic [31:0]   w_head_pc;

    always_comb begin
        w_used     = (CW+2)'(r_live) + (CW+2)'(r_drop) + (CW+2)'(r_cnt);
        w_req      = !rst && !jp_en && (w_used < (CW+2)'(DEPTH));
        w_gnt      = w_req && imem_gnt;
        // responses with nothing outstanding are protocol errors and ignored
        w_rsp      = imem_rvalid && ((r_live != '0) || (r_drop != '0));
        w_stale    = (r_drop != '0);
        w_rsp_live = w_rsp && !w_stale && !jp_en;
        w_fifo_vld = (r_cnt != '0);
        w_head_pc  = r_apc[r_a_rp];
`ifdef IFETCH_BYPASS_EN
        w_byp      = !w_fifo_vld && w_rsp_live;
`else
        w_byp      = 1'b0;
`endif
        w_pop      = w_fifo_vld && dec_ready && !jp_en;
        w_push     = w_rsp_live && !(w_byp && dec_ready);
    end

    assign imem_req   = w_req;
    assign imem_addr  = pc_addr;
    assign pc_stall   = rst || (!w_gnt && !jp_en);
    assign inst_valid = w_fifo_vld || w_byp;
    assign inst       = w_fifo_vld ? r_oinst[r_o_rp] : (w_byp ? imem_rdata : '0);
    assign inst_pc    = w_fifo_vld ? r_opc[r_o_rp]   : (w_byp ? w_head_pc  : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_wp <= '0;
            r_a_rp <= '0;
            r_o_wp <= '0;
            r_o_rp <= '0;
            r_live <= '0;
            r_drop <= '0;
            r_cnt  <= '0;
        end else if (jp_en) begin
            // live requests become stale; a response arriving now retires one of them
            r_a_wp <= '0;
            r_a_rp <= '0;
            r_o_wp <= '0;
            r_o_rp <= '0;
            r_cnt  <= '0;
            r_live <= '0;
            r_drop <= r_drop + r_live - CW'(w_rsp);
        end else begin
            r_a_wp <= r_a_wp + PW'(w_gnt);
            r_a_rp <= r_a_rp + PW'(w_rsp_live);
            r_o_wp <= r_o_wp + PW'(w_push);
            r_o_rp <= r_o_rp + PW'(w_pop);
            r_cnt  <= r_cnt + CW'(w_push) - CW'(w_pop);
            r_live <= r_live + CW'(w_gnt) - CW'(w_rsp_live);
            r_drop <= r_drop - CW'(w_rsp && w_stale);
        end
    end

    always_ff @(posedge clk) begin
        if (w_gnt) begin
            r_apc[r_a_wp] <= pc_addr;
        end
        if (w_push) begin
            r_opc[r_o_wp]   <= w_head_pc;
            r_oinst[r_o_wp] <= imem_rdata;
        end
    end

endmodule
